// File: rtl/piano_pkg.sv
// Shared definitions for the piano note datapath: arbiter state encoding,
// grant bit positions and key ID conventions.
package piano_pkg;

  localparam int KEY_ID_BITS_DEFAULT = 4;
  localparam int REST_ID             = 0;

  localparam int GRANT_W    = 3;
  localparam int GRANT_LIVE = 0;
  localparam int GRANT_REC  = 1;
  localparam int GRANT_SONG = 2;

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_GAP  = 2'd1,
    ST_REC  = 2'd2,
    ST_SONG = 2'd3
  } arb_state_t;

  // One-hot grant for a state; the handover gap grants nobody.
  function automatic logic [GRANT_W-1:0] grant_of(input arb_state_t s);
    logic [GRANT_W-1:0] g;
    g = '0;
    case (s)
      ST_LIVE: g[GRANT_LIVE] = 1'b1;
      ST_REC:  g[GRANT_REC]  = 1'b1;
      ST_SONG: g[GRANT_SONG] = 1'b1;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mute_gap_timer.sv
// Counts the muted handover gap. Held at zero while load is high; once load
// drops it counts 0..GAP_CYCLES-1 and flags done on the last gap cycle.
module mute_gap_timer #(
  parameter int GAP_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count != CNT_W'(LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = !load && (count == CNT_W'(LAST));

endmodule

// File: rtl/sound_source_arbiter.sv
// Registered, non-preemptive arbiter for the buzzer/seven-segment note path
// with a muted gap on every handover. Optional macro ARB_LIVE_OVERRIDE_EN lets
// pressed live keys be heard over recorder or song playback.
module sound_source_arbiter
  import piano_pkg::*;
#(
  parameter int KEY_ID_BITS = KEY_ID_BITS_DEFAULT,
  parameter int GAP_CYCLES  = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_ID_BITS-1:0] live_key_id,
  input  logic                   live_pressed,
  input  logic                   live_oct_up,
  input  logic                   live_oct_down,
  input  logic [KEY_ID_BITS-1:0] rec_key_id,
  input  logic                   rec_pressed,
  input  logic                   rec_oct_up,
  input  logic                   rec_oct_down,
  input  logic [KEY_ID_BITS-1:0] song_key_id,
  input  logic                   song_pressed,
  input  logic                   song_oct_up,
  input  logic                   song_oct_down,
  input  logic                   rec_busy,
  input  logic                   song_busy,
  input  logic                   record_level_in,
  input  logic                   playback_pulse_in,
  input  logic                   song_level_in,
  output logic                   record_level_out,
  output logic                   playback_pulse_out,
  output logic                   song_level_out,
  output logic [KEY_ID_BITS-1:0] out_key_id,
  output logic                   out_pressed,
  output logic                   out_oct_up,
  output logic                   out_oct_down,
  output logic [GRANT_W-1:0]     grant,
  output logic                   mute
);

  localparam bit GAP_EN = (GAP_CYCLES > 0);

  arb_state_t state;
  arb_state_t target;
  logic       gap_done;

  mute_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state != ST_GAP),
    .done (gap_done)
  );

  logic                   live_override;
  logic [KEY_ID_BITS-1:0] sel_key;
  logic                   sel_pressed;
  logic                   sel_up;
  logic                   sel_down;
  logic                   rec_gate;
  logic                   pb_gate;
  logic                   song_gate;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
`ifdef ARB_LIVE_OVERRIDE_EN
    live_override = live_pressed && (live_key_id != KEY_ID_BITS'(REST_ID));
`else
    live_override = 1'b0;
`endif
    sel_key     = KEY_ID_BITS'(REST_ID);
    sel_pressed = 1'b0;
    sel_up      = 1'b0;
    sel_down    = 1'b0;
    case (state)
      ST_LIVE: begin
        sel_key     = live_key_id;
        sel_pressed = live_pressed;
        sel_up      = live_oct_up;
        sel_down    = live_oct_down;
      end
      ST_REC: begin
        sel_key     = live_override ? live_key_id   : rec_key_id;
        sel_pressed = live_override ? live_pressed  : rec_pressed;
        sel_up      = live_override ? live_oct_up   : rec_oct_up;
        sel_down    = live_override ? live_oct_down : rec_oct_down;
      end
      ST_SONG: begin
        sel_key     = live_override ? live_key_id   : song_key_id;
        sel_pressed = live_override ? live_pressed  : song_pressed;
        sel_up      = live_override ? live_oct_up   : song_oct_up;
        sel_down    = live_override ? live_oct_down : song_oct_down;
      end
      default: ;
    endcase

    // Only one activity may start at a time; recording claims priority.
    rec_gate  = (state == ST_LIVE) && record_level_in;
    pb_gate   = (state == ST_LIVE) && !rec_gate && !song_level_in && playback_pulse_in;
    song_gate = song_level_in && !rec_gate &&
                ((state == ST_LIVE) || (state == ST_SONG) ||
                 ((state == ST_GAP) && (target == ST_SONG)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_LIVE;
      target             <= ST_LIVE;
      out_key_id         <= KEY_ID_BITS'(REST_ID);
      out_pressed        <= 1'b0;
      out_oct_up         <= 1'b0;
      out_oct_down       <= 1'b0;
      grant              <= grant_of(ST_LIVE);
      mute               <= 1'b0;
      record_level_out   <= 1'b0;
      playback_pulse_out <= 1'b0;
      song_level_out     <= 1'b0;
    end else begin
      case (state)
        ST_LIVE: begin
          if (song_busy || rec_busy) begin
            target <= song_busy ? ST_SONG : ST_REC;
            if (GAP_EN) state <= ST_GAP;
            else        state <= song_busy ? ST_SONG : ST_REC;
          end
        end
        ST_GAP: begin
          // A source that gave up during the gap is not granted.
          if (gap_done) begin
            case (target)
              ST_REC:  state <= rec_busy  ? ST_REC  : ST_LIVE;
              ST_SONG: state <= song_busy ? ST_SONG : ST_LIVE;
              default: state <= ST_LIVE;
            endcase
          end
        end
        ST_REC: begin
          if (!rec_busy) begin
            target <= ST_LIVE;
            state  <= GAP_EN ? ST_GAP : ST_LIVE;
          end
        end
        ST_SONG: begin
          if (!song_busy) begin
            target <= ST_LIVE;
            state  <= GAP_EN ? ST_GAP : ST_LIVE;
          end
        end
        default: state <= ST_LIVE;
      endcase

      out_key_id         <= sel_key;
      out_pressed        <= sel_pressed;
      out_oct_up         <= sel_up;
      out_oct_down       <= sel_down;
      grant              <= grant_of(state);
      mute               <= (state == ST_GAP);
      record_level_out   <= rec_gate;
      playback_pulse_out <= pb_gate;
      song_level_out     <= song_gate;
    end
  end

endmodule
